// File: rtl/fu_mul_pipe_pkg.sv
// Shared definitions for the pipelined multiply functional unit:
// product-mode encodings, default widths and operand-signedness helpers.
package fu_mul_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_MUL    = 2'b00,
      MODE_MULH   = 2'b01,
      MODE_MULHSU = 2'b10,
      MODE_MULHU  = 2'b11
   } mul_mode_e;

   localparam int XLEN_DEF  = 32;
   localparam int TAG_W_DEF = 4;

   // rs1 is treated as signed for MULH and MULHSU; MUL does not care.
   function automatic logic a_is_signed(input mul_mode_e m);
      return (m == MODE_MULH) || (m == MODE_MULHSU);
   endfunction

   function automatic logic b_is_signed(input mul_mode_e m);
      return (m == MODE_MULH);
   endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// In-order result buffer shared by the functional units: push/pop/flush,
// combinational head view, valid flag and occupancy count.
module fu_result_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   output logic [CW-1:0]    o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   // Pointers wrap explicitly so non-power-of-two depths stay correct.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop & ~w_empty;
   assign w_do_push = i_push & (~w_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push & ~i_flush) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= ptr_inc(r_wptr);
         end
         if (w_do_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rptr];
   assign o_valid = ~w_empty;
   assign o_count = r_count;

endmodule

// File: rtl/fu_mul_pipe.sv
// Pipelined RV32M-style multiply unit: LAT-stage non-stalling pipe feeding a
// credit-limited in-order result buffer that drains on CDB grants.
module fu_mul_pipe
   import fu_mul_pipe_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int LAT    = 4,
   parameter int DEPTH  = 4,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int NUM_FU = 9,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EN,
   output logic              ready,
   input  logic [1:0]        mode,
   input  logic [XLEN-1:0]   A,
   input  logic [XLEN-1:0]   B,
   input  logic [TAG_W-1:0]  tag,
   input  logic              flush,
   output logic [XLEN-1:0]   res,
   output logic [TAG_W-1:0]  res_tag,
   output logic              finish,
   input  logic [NUM_FU-1:0] CDB_result,
   input  logic [IDX_W-1:0]  index
);

   localparam int PW = 2 * XLEN;
   localparam int FW = XLEN + TAG_W;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH + LAT + 1);

   mul_mode_e w_mode;
   logic      w_acc;
   logic      w_pop;

   logic [PW-1:0] w_ea;
   logic [PW-1:0] w_eb;

   // Stage 0 holds the extended operands; the multiply sits between stage 0 and 1.
   logic [PW-1:0]    r_ea;
   logic [PW-1:0]    r_eb;
   mul_mode_e        r_mode;
   logic [LAT-1:0]   r_vld;
   logic [TAG_W-1:0] r_tag [LAT];

   logic [PW-1:0]    w_prod;
   logic [XLEN-1:0]  w_res0;
   logic [XLEN-1:0]  w_res_chain [LAT];

   logic             w_fifo_valid;
   logic [FW-1:0]    w_fifo_dout;
   logic [CW-1:0]    w_fifo_count;
   logic [IW-1:0]    w_inflight;

   assign w_mode = mul_mode_e'(mode);
   assign w_acc  = EN & ready & ~flush;
   assign w_pop  = finish & CDB_result[index];

   // Sign- or zero-extension to 2*XLEN keeps the low 2*XLEN product bits exact.
   assign w_ea = a_is_signed(w_mode) ? {{XLEN{A[XLEN-1]}}, A} : {{XLEN{1'b0}}, A};
   assign w_eb = b_is_signed(w_mode) ? {{XLEN{B[XLEN-1]}}, B} : {{XLEN{1'b0}}, B};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else if (flush) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_acc;
         for (int i = 1; i < LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_ea     <= w_ea;
         r_eb     <= w_eb;
         r_mode   <= w_mode;
         r_tag[0] <= tag;
      end
      for (int i = 1; i < LAT; i++) begin
         r_tag[i] <= r_tag[i-1];
      end
   end

   assign w_prod = r_ea * r_eb;
   assign w_res0 = (r_mode == MODE_MUL) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
   assign w_res_chain[0] = w_res0;

   generate
      for (genvar gi = 1; gi < LAT; gi++) begin : g_stage
         logic [XLEN-1:0] r_res;
         always_ff @(posedge clk) begin
            r_res <= w_res_chain[gi-1];
         end
         assign w_res_chain[gi] = r_res;
      end
   endgenerate

   fu_result_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_vld[LAT-1]),
      .i_din   ({r_tag[LAT-1], w_res_chain[LAT-1]}),
      .i_pop   (w_pop),
      .i_flush (flush),
      .o_dout  (w_fifo_dout),
      .o_valid (w_fifo_valid),
      .o_count (w_fifo_count)
   );

   // Credits cover both the pipe and the buffer, so the buffer can never overflow.
   always_comb begin
      w_inflight = IW'(w_fifo_count);
      for (int i = 0; i < LAT; i++) begin
         w_inflight = w_inflight + IW'(r_vld[i]);
      end
   end

   assign ready   = (w_inflight < IW'(DEPTH));
   assign finish  = w_fifo_valid;
   assign res     = w_fifo_valid ? w_fifo_dout[XLEN-1:0] : '0;
   assign res_tag = w_fifo_valid ? w_fifo_dout[FW-1:XLEN] : '0;

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Randomised and directed bench for fu_mul_pipe against a timing-aware
// queue model of the unit (results from wide arithmetic, due cycle per op).
module tb_fu_mul_pipe;

   localparam int XLEN   = 32;
   localparam int LAT    = 3;
   localparam int DEPTH  = 4;
   localparam int TAG_W  = 4;
   localparam int NUM_FU = 9;
   localparam int IDX_W  = 4;
   localparam int IDX    = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              EN = 1'b0;
   logic              ready;
   logic [1:0]        mode = 2'b00;
   logic [XLEN-1:0]   A = '0;
   logic [XLEN-1:0]   B = '0;
   logic [TAG_W-1:0]  tag = '0;
   logic              flush = 1'b0;
   logic [XLEN-1:0]   res;
   logic [TAG_W-1:0]  res_tag;
   logic              finish;
   logic [NUM_FU-1:0] CDB_result = '0;
   logic [IDX_W-1:0]  index = IDX_W'(IDX);

   fu_mul_pipe #(
      .XLEN(XLEN), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W),
      .NUM_FU(NUM_FU), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .EN(EN), .ready(ready), .mode(mode),
      .A(A), .B(B), .tag(tag), .flush(flush), .res(res),
      .res_tag(res_tag), .finish(finish), .CDB_result(CDB_result),
      .index(index)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] tag;
      int               due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   localparam logic [NUM_FU-1:0] GNT_ME    = NUM_FU'(1) << IDX;
   localparam logic [NUM_FU-1:0] GNT_OTHER = NUM_FU'(1) << 2;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
      end
   endtask

   // Product from the mode rules with 128-bit arithmetic.
   function automatic logic [XLEN-1:0] model(input logic [1:0] md,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      logic signed [127:0] pa, pb, p;
      pa = (md == 2'b01 || md == 2'b10) ? 128'($signed(a)) : {96'b0, a};
      pb = (md == 2'b01) ? 128'($signed(b)) : {96'b0, b};
      p  = pa * pb;
      return (md == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // One cycle: drive, check outputs against the model, advance one edge.
   task automatic step(input logic en, input logic [1:0] md,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tg, input logic fl,
                       input logic [NUM_FU-1:0] gv);
      bit exp_fin, exp_rdy;
      EN = en; mode = md; A = a; B = b; tag = tg; flush = fl; CDB_result = gv;
      #1;
      exp_fin = (q.size() > 0) && (q[0].due <= cyc);
      exp_rdy = (q.size() < DEPTH);
      chk("ready", 64'(ready), 64'(exp_rdy));
      chk("finish", 64'(finish), 64'(exp_fin));
      if (exp_fin) begin
         chk("res", 64'(res), 64'(q[0].res));
         chk("res_tag", 64'(res_tag), 64'(q[0].tag));
      end else begin
         chk("res_empty", 64'(res), 64'd0);
         chk("tag_empty", 64'(res_tag), 64'd0);
      end
      if (fl) begin
         q.delete();
      end else begin
         if (exp_fin && gv[IDX]) void'(q.pop_front());
         if (en && exp_rdy) q.push_back('{model(md, a, b), tg, cyc + LAT + 1});
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n, input logic [NUM_FU-1:0] gv);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, '0, 1'b0, gv);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && q.size() > 0; i++) step(1'b0, 2'b00, '0, '0, '0, 1'b0, GNT_ME);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      logic [XLEN-1:0] ra, rb;
      logic [NUM_FU-1:0] gv;
      int r;

      // Reset state
      #2;
      chk("rst_finish", 64'(finish), 64'd0);
      chk("rst_res", 64'(res), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: MUL 7*6, grant held
      step(1'b1, 2'b00, 32'd7, 32'd6, 4'd3, 1'b0, GNT_ME);
      idle(LAT + 3, GNT_ME);
      $display("t1 mul 7*6 done cyc=%0d", cyc);

      // 2: all modes with A=-1, B=2
      for (int m = 0; m < 4; m++)
         step(1'b1, 2'(m), 32'hFFFF_FFFF, 32'd2, 4'(m + 8), 1'b0, GNT_ME);
      drain();
      $display("t2 modes done cyc=%0d", cyc);

      // 3: back-to-back squares
      for (int i = 1; i <= 8; i++)
         step(1'b1, 2'b00, 32'(i), 32'(i), 4'(i), 1'b0, GNT_ME);
      drain();
      $display("t3 back-to-back done cyc=%0d", cyc);

      // 4: grant withheld, then single grant
      for (int i = 0; i < DEPTH + 4; i++)
         step(1'b1, 2'b11, 32'(1000 + i), 32'hDEAD_0000, 4'(i), 1'b0, '0);
      step(1'b1, 2'b00, 32'd50, 32'd3, 4'd12, 1'b0, GNT_ME);
      for (int i = 0; i < 3; i++)
         step(1'b1, 2'b00, 32'(60 + i), 32'd3, 4'(13 + i), 1'b0, '0);
      drain();
      $display("t4 credit throttle done cyc=%0d", cyc);

      // 5: flush with ops in pipe and buffer, EN in the flush cycle
      for (int i = 0; i < 4; i++)
         step(1'b1, 2'b00, 32'(20 + i), 32'd5, 4'(i + 1), 1'b0, '0);
      idle(1, '0);
      step(1'b1, 2'b00, 32'd99, 32'd99, 4'd15, 1'b1, GNT_ME);
      idle(LAT + 4, GNT_ME);
      step(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 4'd6, 1'b0, GNT_ME);
      drain();
      $display("t5 flush done cyc=%0d", cyc);

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 3; i++)
         step(1'b1, 2'b00, 32'(300 + i), 32'd7, 4'(i), 1'b0, '0);
      idle(2, '0);
      EN = 1'b0; CDB_result = '0;
      #1 rst = 1'b1;
      #1;
      chk("arst_finish", 64'(finish), 64'd0);
      chk("arst_res", 64'(res), 64'd0);
      chk("arst_ready", 64'(ready), 64'd1);
      q.delete();
      @(posedge clk);
      cyc++;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      step(1'b1, 2'b10, 32'hFFFF_FFF0, 32'd16, 4'd9, 1'b0, GNT_ME);
      drain();
      $display("t6 async reset done cyc=%0d", cyc);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         gv = (r < 7) ? GNT_ME : ((r == 7) ? GNT_OTHER : '0);
         case ($urandom_range(0, 3))
            0:       ra = 32'hFFFF_FFFF;
            1:       ra = 32'h8000_0000;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
         step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra, rb,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 40) == 0), gv);
      end
      drain();
      $display("t7 random done cyc=%0d", cyc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
